// File: rtl/spm_seq_ctrl_pkg.sv
// Shared definitions for the SPM sequencer: FSM states, instruction field
// layout and the width derivations used by the interface and both modules.
package spm_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Per-channel field, LSB first: mode, sel, en, fifo_sel[FSW], flush
    localparam int FLD_MODE = 0;
    localparam int FLD_SEL  = 1;
    localparam int FLD_EN   = 2;
    localparam int FLD_FSEL = 3;

    function automatic int fld_w(input int fsw);
        return 4 + fsw;
    endfunction

    function automatic int inst_w(input int nbg, input int fsw);
        return nbg * (4 + fsw);
    endfunction

    function automatic int sw_w(input int dw, input int aw);
        return 2 + dw + aw;
    endfunction

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Config, run-control, external-port and bank-group bus of the SPM sequencer.
interface spm_seq_ctrl_if
    import spm_seq_ctrl_pkg::*;
#(
    parameter int NUM_BG = 4,
    parameter int DW     = 32,
    parameter int AW     = 8,
    parameter int FSW    = 2
);
    localparam int BW     = $clog2(NUM_BG);
    localparam int INST_W = inst_w(NUM_BG, FSW);
    localparam int SW     = sw_w(DW, AW);

    logic                  cfg_valid;
    logic [INST_W-1:0]     cfg_inst;
    logic                  cfg_ready;
    logic                  cfg_clear;
    logic                  start;
    logic [15:0]           loop_num;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic                  ex_we;
    logic                  ex_re;
    logic [BW-1:0]         ex_wsel;
    logic [BW-1:0]         ex_rsel;
    logic [AW-1:0]         ex_addr;
    logic [DW-1:0]         ex_data;
    logic [DW-1:0]         ex_rdata;
    logic [NUM_BG*SW-1:0]  sw_in;
    logic [NUM_BG*DW-1:0]  bg_rdata;
    logic [NUM_BG-1:0]     bg_en;
    logic [NUM_BG-1:0]     bg_mode;
    logic [NUM_BG-1:0]     bg_we;
    logic [NUM_BG-1:0]     bg_re;
    logic [NUM_BG-1:0]     bg_flush;
    logic [NUM_BG*FSW-1:0] bg_fifo_sel;
    logic [NUM_BG*AW-1:0]  bg_addr;
    logic [NUM_BG*DW-1:0]  bg_din;

    modport master (
        output cfg_valid, cfg_inst, cfg_clear, start, loop_num, stall,
               ex_we, ex_re, ex_wsel, ex_rsel, ex_addr, ex_data, sw_in, bg_rdata,
        input  cfg_ready, busy, done, ex_rdata,
               bg_en, bg_mode, bg_we, bg_re, bg_flush, bg_fifo_sel, bg_addr, bg_din
    );

    modport slave (
        input  cfg_valid, cfg_inst, cfg_clear, start, loop_num, stall,
               ex_we, ex_re, ex_wsel, ex_rsel, ex_addr, ex_data, sw_in, bg_rdata,
        output cfg_ready, busy, done, ex_rdata,
               bg_en, bg_mode, bg_we, bg_re, bg_flush, bg_fifo_sel, bg_addr, bg_din
    );

endinterface

// File: rtl/spm_seq_ctrl_cfg_seq.sv
// Config buffer and replay FSM: stores up to DEPTH instruction words and
// steps through them loop_num times, one word per non-stalled cycle.
module spm_cfg_seq
    import spm_seq_ctrl_pkg::*;
#(
    parameter int INST_W = 24,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cfg_valid,
    input  logic [INST_W-1:0] i_cfg_inst,
    output logic              o_cfg_ready,
    input  logic              i_cfg_clear,
    input  logic              i_start,
    input  logic [15:0]       i_loop_num,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic [INST_W-1:0] o_inst
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INST_W-1:0] r_buf [DEPTH];
    seq_state_e        r_state;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [15:0]       r_pass;
    logic [15:0]       r_passes;
    logic [INST_W-1:0] r_inst;
    logic              r_busy;
    logic              r_done;

    logic              w_wr;
    logic              w_wrap;
    logic              w_final;
    logic [15:0]       w_passes_in;

    assign o_cfg_ready = (r_state == ST_IDLE) && (r_count < CW'(DEPTH));
    assign w_wr        = o_cfg_ready && i_cfg_valid && !i_cfg_clear;
    assign w_wrap      = ({1'b0, r_rd_ptr} == r_count - CW'(1));
    assign w_final     = w_wrap && (r_pass == r_passes - 16'd1);
    assign w_passes_in = (i_loop_num == 16'd0) ? 16'd1 : i_loop_num;

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_inst = r_inst;

    always_ff @(posedge clk) begin
        if (w_wr) r_buf[r_count[PW-1:0]] <= i_cfg_inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_pass   <= '0;
            r_passes <= '0;
            r_inst   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_clear)  r_count <= '0;
                    else if (w_wr)    r_count <= r_count + 1'b1;
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (r_count == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_inst   <= r_buf[0];
                            r_passes <= w_passes_in;
                            // A single-entry program finishes pass 0 on the start edge itself
                            r_rd_ptr <= (r_count == CW'(1)) ? '0 : PW'(1);
                            r_pass   <= (r_count == CW'(1)) ? 16'd1 : 16'd0;
                            if (r_count == CW'(1) && w_passes_in == 16'd1) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (!i_stall) begin
                        r_inst   <= r_buf[r_rd_ptr];
                        r_rd_ptr <= w_wrap ? '0 : r_rd_ptr + 1'b1;
                        if (w_wrap) r_pass <= r_pass + 16'd1;
                        if (w_final) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_inst  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spm_seq_ctrl.sv
// SPM sequencer top: replays configured instruction words and steers each
// bank-group channel to either its switch input or the shared external port.
module spm_seq_ctrl
    import spm_seq_ctrl_pkg::*;
#(
    parameter int NUM_BG = 4,
    parameter int DW     = 32,
    parameter int AW     = 8,
    parameter int DEPTH  = 64,
    parameter int FSW    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spm_seq_ctrl_if.slave bus
);
    localparam int F      = fld_w(FSW);
    localparam int INST_W = inst_w(NUM_BG, FSW);
    localparam int SW     = sw_w(DW, AW);
    localparam int BW     = $clog2(NUM_BG);

    logic [INST_W-1:0]          w_inst;
    logic [NUM_BG-1:0][DW-1:0]  w_rd_arr;
    logic [DW-1:0]              r_ex_rdata;

    spm_cfg_seq #(.INST_W(INST_W), .DEPTH(DEPTH)) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cfg_valid (bus.cfg_valid),
        .i_cfg_inst  (bus.cfg_inst),
        .o_cfg_ready (bus.cfg_ready),
        .i_cfg_clear (bus.cfg_clear),
        .i_start     (bus.start),
        .i_loop_num  (bus.loop_num),
        .i_stall     (bus.stall),
        .o_busy      (bus.busy),
        .o_done      (bus.done),
        .o_inst      (w_inst)
    );

    for (genvar k = 0; k < NUM_BG; k++) begin : g_ch
        logic [F-1:0]  w_fld;
        logic [SW-1:0] w_sw;
        logic          w_sel;

        assign w_fld = w_inst[k*F +: F];
        assign w_sw  = bus.sw_in[k*SW +: SW];
        assign w_sel = w_fld[FLD_SEL];

        assign bus.bg_mode[k]                = w_fld[FLD_MODE];
        assign bus.bg_en[k]                  = w_fld[FLD_EN];
        assign bus.bg_fifo_sel[k*FSW +: FSW] = w_fld[FLD_FSEL +: FSW];
        assign bus.bg_flush[k]               = w_fld[F-1];

        // Switch word layout, MSB first: wen, data, ren, addr
        assign bus.bg_addr[k*AW +: AW] = w_sel ? w_sw[AW-1:0]    : bus.ex_addr;
        assign bus.bg_din[k*DW +: DW]  = w_sel ? w_sw[AW+1 +: DW] : bus.ex_data;
        assign bus.bg_we[k] = w_sel ? w_sw[SW-1] : (bus.ex_we && (bus.ex_wsel == BW'(k)));
        assign bus.bg_re[k] = w_sel ? w_sw[AW]   : (bus.ex_re && (bus.ex_rsel == BW'(k)));
    end

    assign w_rd_arr     = bus.bg_rdata;
    assign bus.ex_rdata = r_ex_rdata;

    // Out-of-range read selects return zero rather than an undefined lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rdata <= '0;
        end else if (bus.ex_re) begin
            r_ex_rdata <= ({1'b0, bus.ex_rsel} < (BW+1)'(NUM_BG)) ? w_rd_arr[bus.ex_rsel] : '0;
        end
    end

endmodule

// File: doc/spm_seq_ctrl.md
SPM_SEQ_CTRL -- requirements
Module: spm_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_BG, default 4: number of bank-group channels, 2..8.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter AW, default 8: bank address width.
REQ-004 SHALL have parameter DEPTH, default 64: config buffer entries, power of two.
REQ-005 SHALL have parameter FSW, default 2: per-channel fifo_sel width; derived F=4+FSW, INST_W=NUM_BG*F, SW=2+DW+AW, BW=clog2(NUM_BG).
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 cfg_valid in 1, cfg_inst in INST_W, cfg_ready out 1: config load handshake.
REQ-010 cfg_clear in 1: empties config buffer (IDLE only).
REQ-011 start in 1, loop_num in 16, stall in 1: run control; busy out 1, done out 1.
REQ-012 ex_we in 1, ex_re in 1, ex_wsel in BW, ex_rsel in BW, ex_addr in AW, ex_data in DW, ex_rdata out DW: external port.
REQ-013 sw_in in NUM_BG*SW: per channel k at [k*SW +: SW], packed {wen, data, ren, addr} MSB->LSB.
REQ-014 bg_rdata in NUM_BG*DW: per-channel bank-group read data.
REQ-015 bg_en, bg_mode, bg_we, bg_re, bg_flush out NUM_BG each; bg_fifo_sel out NUM_BG*FSW; bg_addr out NUM_BG*AW; bg_din out NUM_BG*DW.

Function
REQ-016 Instruction field k at [k*F +: F], MSB->LSB {flush, fifo_sel, en, sel, mode}.
REQ-017 cfg_ready SHALL be high iff state IDLE and count<DEPTH; cfg_valid&cfg_ready writes buf[count], count+1.
REQ-018 cfg_clear in IDLE SHALL set count=0 next edge, priority over a simultaneous write; ignored outside IDLE.
REQ-019 FSM states IDLE, RUN, DONE; busy high in RUN and DONE; start ignored unless IDLE.
REQ-020 start in IDLE with count=0 SHALL go to DONE for one cycle, inst_r stays 0.
REQ-021 start in IDLE with count>0 SHALL, on that edge: state RUN, inst_r<=buf[0], rd_ptr<=1 mod count, pass<=0; passes P=max(loop_num,1) latched.
REQ-022 Each RUN edge with stall low SHALL load inst_r<=buf[rd_ptr]; rd_ptr wraps count-1->0 and increments pass.
REQ-023 The edge loading entry count-1 of pass P-1 SHALL move to DONE; DONE->IDLE next edge with inst_r<=0.
REQ-024 stall high in RUN SHALL freeze inst_r, rd_ptr, pass; stall ignored in IDLE/DONE.
REQ-025 done SHALL be high exactly during the DONE cycle; each instruction active count*P cycles total excluding stalls.
REQ-026 bg_en/mode/fifo_sel/flush SHALL come directly from inst_r fields; in IDLE all zero.
REQ-027 Channel k sel=1: bg_addr/bg_din/bg_we/bg_re from sw_in channel k; sel=0: ex_addr, ex_data, ex_we&(ex_wsel==k), ex_re&(ex_rsel==k).
REQ-028 ex_rdata SHALL register bg_rdata[ex_rsel] each edge ex_re high, else hold; one-cycle latency.
REQ-029 ex_wsel/ex_rsel >= NUM_BG SHALL select no channel; ex_rdata then loads 0.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, count=0, rd_ptr=0, pass=0, inst_r=0, ex_rdata=0, done=0, busy=0; buffer contents need not clear.
REQ-031 Reset asserted mid-RUN SHALL abort with no done pulse; after release cfg_ready is high.

Structure
REQ-032 State encoding, field offsets and F/INST_W/SW derivation SHALL live in the shared spm package.
REQ-033 The buffer plus FSM SHALL be sub-module spm_cfg_seq; channel muxing stays in spm_seq_ctrl.

Verification
REQ-034 Load 3 entries, loop_num=2, start -> inst_r sequence e0,e1,e2,e0,e1,e2; done high with second e2; busy 6 cycles.
REQ-035 Stall 2 cycles during e1 of pass 0 -> e1 held 3 cycles; done 2 cycles later than REQ-034.
REQ-036 Load 64 entries -> cfg_ready low; 65th cfg_valid dropped; cfg_clear -> cfg_ready high, count=0.
REQ-037 count=0, start -> done one cycle later, bg_en stays 0.
REQ-038 Channel 2 sel=0, ex_we=1, ex_wsel=2, ex_addr=0x15 -> only bg_we[2]=1, bg_addr[2]=0x15; ex_re=1, ex_rsel=2, bg_rdata[2]=0xDEADBEEF -> ex_rdata=0xDEADBEEF next cycle.
REQ-039 rst low mid-RUN of pass 1 -> outputs zero immediately, no done, IDLE after release.
